// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receiver and the planned transmitter:
// parity mode encodings, the receiver state enum and a parity helper.
// No ports; imported with import uart_pkg::*.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  // Mode 2'b11 is treated the same as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Narrow words are zero-extended by the caller; the extra zeros do not
  // change the XOR, so one 8-bit helper covers every legal data width.
  function automatic logic parity_ok(input logic [1:0] mode,
                                     input logic [7:0] data,
                                     input logic       par_bit);
    logic ones_odd;
    ones_odd = (^data) ^ par_bit;
    case (mode)
      PAR_EVEN: return !ones_odd;
      PAR_ODD:  return ones_odd;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO holding received frames.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write request and word
//   pop             read request (ignored while empty)
//   head_data       oldest entry, 0 while empty
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags
// A push while full is only accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Oversampling UART receiver (LSB first, optional parity, 1 or 2 stop bits)
// feeding a FWFT receive FIFO, with sticky error flags.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   tick_div                  clk cycles per oversample tick (0 acts as 1)
//   rx                        asynchronous serial input, idle high
//   parity_mode, stop2        frame format, latched when a start bit is accepted
//   rd_en, rd_data, rd_valid  FIFO read side
//   fifo_count                FIFO occupancy
//   frame_err, parity_err,
//   overrun, clr_err          sticky errors and their clear
//   busy                      receiver is inside a frame
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              tick_div,
  input  logic                          rx,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [SCW-1:0] HALF_TICK = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] LAST_TICK = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  rx_state_e            state_q, state_d;
  logic [SCW-1:0]       samp_cnt_q, samp_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 two_stop_q, two_stop_d;
  logic                 bad_q, bad_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sample_pt, fe_evt, pe_evt, ov_evt;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // The divider value is captured only on a tick, so a new tick_div
  // takes effect at the next wrap. div_q resets to 1 so the first tick
  // loads the programmed value.
  always_comb begin
    tick       = (tick_cnt_q == div_q - DIV_W'(1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    div_d      = div_q;
    if (tick) begin
      div_d = (tick_div == '0) ? DIV_W'(1) : tick_div;
    end
  end

  // Frame state machine. sample_pt marks the tick at which the current
  // bit is read: half a bit into START, then one full bit per later bit.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    bad_d      = bad_q;
    push_d     = 1'b0;
    fe_evt     = 1'b0;
    pe_evt     = 1'b0;
    sample_pt  = tick && (samp_cnt_q == ((state_q == ST_START) ? HALF_TICK : LAST_TICK));

    if (state_q != ST_IDLE && tick) begin
      samp_cnt_d = sample_pt ? '0 : samp_cnt_q + SCW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        samp_cnt_d = '0;
        if (tick && !rx_sync_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sample_pt) begin
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            bad_d      = 1'b0;
            par_mode_d = parity_mode;
            two_stop_d = stop2;
          end
        end
      end
      ST_DATA: begin
        if (sample_pt) begin
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_pt) begin
          if (!parity_ok(par_mode_q, 8'(shift_q), rx_sync_q)) begin
            bad_d  = 1'b1;
            pe_evt = 1'b1;
          end
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (sample_pt) begin
          if (!rx_sync_q) begin
            bad_d  = 1'b1;
            fe_evt = 1'b1;
          end
          if (two_stop_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            push_d  = !bad_q && rx_sync_q;
          end
        end
      end
      ST_STOP2: begin
        if (sample_pt) begin
          if (!rx_sync_q) begin
            fe_evt = 1'b1;
          end
          state_d = ST_IDLE;
          push_d  = !bad_q && rx_sync_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
  // A push into a full FIFO only counts as overrun when no pop frees a slot.
  always_comb begin
    ov_evt       = push_q && fifo_full && !rd_en;
    frame_err_d  = (frame_err_q  && !clr_err) || fe_evt;
    parity_err_d = (parity_err_q && !clr_err) || pe_evt;
    overrun_d    = (overrun_q    && !clr_err) || ov_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q   <= '0;
      div_q        <= DIV_W'(1);
      state_q      <= ST_IDLE;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_mode_q   <= PAR_NONE;
      two_stop_q   <= 1'b0;
      bad_q        <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      div_q        <= div_d;
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_mode_q   <= par_mode_d;
      two_stop_q   <= two_stop_d;
      bad_q        <= bad_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (rd_en),
    .head_data (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid   = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Drives serial frames into uart_rx_fifo and checks the FIFO/flag outputs
// against a queue-based model of which frames must be kept.
module tb_uart_rx_fifo;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] tick_div = 16'd12;
  logic          rx = 1'b1;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DB-1:0] rd_data;
  logic          rd_valid;
  logic [3:0]    fifo_count;
  logic          frame_err, parity_err, overrun, busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  int          bit_cyc = 12 * OS;
  logic [7:0]  exp_q[$];
  logic        exp_fe = 1'b0;
  logic        exp_pe = 1'b0;
  logic        exp_ov = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .DIV_W      (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_div    (tick_div),
    .rx          (rx),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .clr_err     (clr_err),
    .busy        (busy)
  );

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whenever no frame is in flight, every output must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("rd_valid", int'(rd_valid), int'(exp_q.size() != 0));
      check_output("fifo_count", int'(fifo_count), exp_q.size());
      if (exp_q.size() != 0) check_output("rd_data", int'(rd_data), int'(exp_q[0]));
      check_output("frame_err", int'(frame_err), int'(exp_fe));
      check_output("parity_err", int'(parity_err), int'(exp_pe));
      check_output("overrun", int'(overrun), int'(exp_ov));
      check_output("busy", int'(busy), 0);
    end
  end

  task automatic drive_level(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  // A bad stop bit is low only a little past its middle, so the line is
  // high again well before the receiver could accept a new start bit.
  task automatic drive_stop(input logic ok);
    if (ok) begin
      drive_level(1'b1, bit_cyc);
    end else begin
      drive_level(1'b0, bit_cyc / 2 + 4 * int'(tick_div));
      drive_level(1'b1, bit_cyc / 2 - 4 * int'(tick_div));
    end
  endtask

  // Sends one frame with the current parity_mode/stop2 settings, then
  // applies the frame rules to the model.
  task automatic apply_stimulus(input logic [7:0] data, input logic pbit,
                                input logic s1_ok, input logic s2_ok);
    logic par_en, pe, fe;
    chk_en = 1'b0;
    par_en = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    drive_level(1'b0, bit_cyc);
    for (int i = 0; i < DB; i++) drive_level(data[i], bit_cyc);
    if (par_en) drive_level(pbit, bit_cyc);
    drive_stop(s1_ok);
    if (stop2) drive_stop(s2_ok);
    drive_level(1'b1, 2 * bit_cyc);
    pe = par_en && (((^data) ^ pbit) != (parity_mode == 2'b10));
    fe = !s1_ok || (stop2 && !s2_ok);
    if (pe) exp_pe = 1'b1;
    if (fe) exp_fe = 1'b1;
    if (!pe && !fe) begin
      if (exp_q.size() < FD) exp_q.push_back(data);
      else exp_ov = 1'b1;
    end
    chk_en = 1'b1;
  endtask

  task automatic read_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    exp_ov = 1'b0;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int max_cyc, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy === level) begin
        seen = 1'b1;
        break;
      end
    end
    check_output(name, int'(seen), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_rd_valid"}, int'(rd_valid), 0);
    check_output({tag, "_count"}, int'(fifo_count), 0);
    check_output({tag, "_rd_data"}, int'(rd_data), 0);
    check_output({tag, "_fe"}, int'(frame_err), 0);
    check_output({tag, "_pe"}, int'(parity_err), 0);
    check_output({tag, "_ov"}, int'(overrun), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    chk_en = 1'b1;
    drive_level(1'b1, bit_cyc);

    // Basic frame at tick_div=12, no parity, one stop bit.
    apply_stimulus(8'hCB, 1'b0, 1'b1, 1'b1);
    check_output("t1_rd_data", int'(rd_data), 'hCB);
    check_output("t1_count", int'(fifo_count), 1);
    read_one();
    check_output("t1_count_after_pop", int'(fifo_count), 0);

    tick_div = 16'd4;
    bit_cyc = 4 * OS;
    drive_level(1'b1, bit_cyc);

    // Parity: 0x6F has six ones.
    parity_mode = 2'b01;
    apply_stimulus(8'h6F, 1'b0, 1'b1, 1'b1);
    check_output("even_ok_count", int'(fifo_count), 1);
    apply_stimulus(8'h6F, 1'b1, 1'b1, 1'b1);
    check_output("even_bad_pe", int'(parity_err), 1);
    check_output("even_bad_count", int'(fifo_count), 1);
    clear_errors();
    check_output("pe_cleared", int'(parity_err), 0);
    parity_mode = 2'b10;
    apply_stimulus(8'h6F, 1'b1, 1'b1, 1'b1);
    check_output("odd_ok_count", int'(fifo_count), 2);
    parity_mode = 2'b00;
    read_one();
    read_one();

    // Two stop bits, second one low, then a clean 0x55.
    stop2 = 1'b1;
    apply_stimulus(8'h3C, 1'b0, 1'b1, 1'b0);
    check_output("stop2_fe", int'(frame_err), 1);
    check_output("stop2_count", int'(fifo_count), 0);
    apply_stimulus(8'h55, 1'b0, 1'b1, 1'b1);
    check_output("stop2_good_data", int'(rd_data), 'h55);
    read_one();
    clear_errors();
    stop2 = 1'b0;

    // Overflow: nine frames, no reads.
    for (int i = 0; i < FD + 1; i++) apply_stimulus(8'(i * 17 + 3), 1'b0, 1'b1, 1'b1);
    check_output("full_count", int'(fifo_count), 8);
    check_output("full_overrun", int'(overrun), 1);
    check_output("full_head", int'(rd_data), 'h03);
    for (int i = 0; i < FD; i++) begin
      check_output("drain_order", int'(rd_data), (i * 17 + 3) & 8'hFF);
      read_one();
    end
    clear_errors();
    for (int i = 0; i < FD; i++) apply_stimulus(8'(i + 8'h40), 1'b0, 1'b1, 1'b1);

    // Pop on the exact push cycle while full: the push must not overrun.
    fork
      apply_stimulus(8'hE7, 1'b0, 1'b1, 1'b1);
      begin
        wait_busy(1'b1, 2 * bit_cyc, "busy_rise_timeout");
        wait_busy(1'b0, 12 * bit_cyc, "busy_fall_timeout");
        rd_en = 1'b1;
        @(posedge clk);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check_output("pushpop_overrun", int'(overrun), 0);
    check_output("pushpop_count", int'(fifo_count), 8);
    check_output("pushpop_head", int'(rd_data), 'h41);
    for (int i = 0; i < FD; i++) read_one();
    check_output("final_drain_count", int'(fifo_count), 0);

    // Short low pulse of 3 ticks: rejected as a glitch.
    chk_en = 1'b0;
    drive_level(1'b0, 3 * int'(tick_div));
    check_output("glitch_busy_seen", int'(busy), 1);
    drive_level(1'b1, 20 * int'(tick_div));
    check_output("glitch_busy_drop", int'(busy), 0);
    chk_en = 1'b1;

    // Reset in the middle of DATA with one word already queued.
    apply_stimulus(8'h99, 1'b0, 1'b1, 1'b1);
    chk_en = 1'b0;
    drive_level(1'b0, bit_cyc);
    drive_level(1'b1, bit_cyc);
    drive_level(1'b0, bit_cyc);
    drive_level(1'b1, bit_cyc / 2);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    exp_ov = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    drive_level(1'b1, bit_cyc);
    apply_stimulus(8'hA5, 1'b0, 1'b1, 1'b1);
    check_output("after_reset_data", int'(rd_data), 'hA5);
    check_output("after_reset_count", int'(fifo_count), 1);
    read_one();

    chk_en = 1'b0;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with oversampled start-bit validation, runtime-selectable parity and stop-bit count, sticky error reporting and an integrated receive FIFO. Next-generation replacement for the fixed 8-bit receiver: it feeds the host side of the UART top level and decouples serial arrival from host reads. Frame format is LSB first, 1 start bit, DATA_BITS data bits, optional parity and 1 or 2 stop bits.

## Interface

- DATA_BITS, 8, data bits per frame, legal range 5..8
- OVERSAMPLE, 16, ticks per bit, even and at least 8
- DIV_W, 16, width of the tick divider
- FIFO_DEPTH, 8, FIFO entries, power of 2 and at least 2
- clk  in  1  system clock; only clock
- rst  in  1  asynchronous, active-low reset
- tick_div  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
- rx  in  1  asynchronous serial line, idle high
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop2  in  1  1 = two stop bits checked
- rd_en  in  1  pop head of FIFO; ignored when rd_valid=0
- rd_data  out  DATA_BITS  FIFO head (first-word fall-through)
- rd_valid  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- frame_err, parity_err, overrun  out  1 each  sticky error flags
- clr_err  in  1  clears all three sticky flags
- busy  out  1  receiver not in IDLE

## Operation

- rx passes through a 2-flop synchroniser, both flops reset to 1.
- Tick counter free-runs 0..tick_div-1; one-cycle tick at terminal count. New tick_div takes effect at next wrap.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: synchronised rx low on a tick -> START, sample counter cleared.
- START: after OVERSAMPLE/2 ticks sample rx; high -> IDLE (glitch, nothing recorded); low -> DATA.
- DATA: sample every OVERSAMPLE ticks, shift in LSB first; after DATA_BITS samples -> PARITY if parity enabled, else STOP1.
- PARITY: even mode requires XOR(data, parity bit)=0, odd mode =1; mismatch marks frame bad with parity error.
- STOP1: sampled low -> frame bad with framing error. stop2=1 -> STOP2 (same check), else done. parity_mode and stop2 are latched at START acceptance; mid-frame changes have no effect.
- Done: from final stop sample return to IDLE immediately (mid-stop-bit) so the next start edge is caught.
- Good frame: pushed to FIFO. FIFO full on push: frame dropped, overrun set. Bad frame: never pushed; respective flag set.
- Push and pop in same cycle: both happen, count unchanged, no overrun even when full.
- clr_err coincident with a new error: error wins, flag stays 1.
- Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.

## Timing

- Reset: rd_data=0, rd_valid=0, fifo_count=0, all error flags 0, busy=0, FSM IDLE, tick counter 0, FIFO empty.
- Reset mid-frame aborts the frame; no partial push.
- rx to FSM: 2 clk synchroniser latency plus up to 1 tick detection granularity.
- Bit period = tick_div x OVERSAMPLE clk cycles.
- Push occurs the clk after the final stop sample; rd_valid and fifo_count update the following clk edge (registered).
- rd_en pop: rd_data shows next entry and count decrements on the next clk edge.
- Error flags set the clk after the offending sample.

## Structure

- Shared package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), FSM state enum, parity helper function; reused by the future parametrised transmitter.
- One sub-module: uart_sync_fifo (DATA_BITS wide, FIFO_DEPTH deep, FWFT, push/pop/count), instantiated once.

## Test plan

- tick_div=12, no parity, 1 stop, send 0xCB -> rd_valid after stop sample, rd_data=0xCB, count=1, no errors; rd_en -> count=0.
- DATA_BITS=8, even parity, send 0x6F with parity bit 0 -> accepted; send 0x6F with parity bit 1 -> not pushed, parity_err=1; clr_err -> 0.
- stop2=1, second stop driven low -> frame_err=1, FIFO unchanged; next valid 0x55 received correctly.
- Send FIFO_DEPTH+1 frames with no reads -> count=8, overrun=1, contents are first 8 bytes in order; read all, then send with rd_en on push cycle while full -> no overrun.
- rx low pulse of 3 ticks (shorter than OVERSAMPLE/2) -> returns to IDLE, busy drops, no push, no flags.
- Assert rst low mid-DATA -> all outputs at reset values immediately; subsequent 0xA5 frame received cleanly.
